// File: rtl/magnet_pkg.sv
// Shared definitions for the unlock-magnet driver: state encoding and default cycle counts.
package magnet_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PULL_IN  = 2'd1,
      HOLD     = 2'd2,
      COOLDOWN = 2'd3
   } state_t;

   localparam int DEF_CNT_W           = 16;
   localparam int DEF_PULL_IN_CYCLES  = 8;
   localparam int DEF_PWM_PERIOD      = 4;
   localparam int DEF_HOLD_ON_CYCLES  = 1;
   localparam int DEF_MAX_ON_CYCLES   = 64;
   localparam int DEF_COOLDOWN_CYCLES = 16;

   function automatic logic is_busy(state_t s);
      return s != IDLE;
   endfunction

endpackage

// File: rtl/magnet_pwm.sv
// Hold-phase PWM: phase counter with clear/enable and the duty decision for the upcoming cycle.
module magnet_pwm
   import magnet_pkg::*;
#(
   parameter int CNT_W          = DEF_CNT_W,
   parameter int PWM_PERIOD     = DEF_PWM_PERIOD,
   parameter int HOLD_ON_CYCLES = DEF_HOLD_ON_CYCLES
) (
   input  logic clock,
   input  logic ctrl_reset_n,
   input  logic enable,
   input  logic clear,
   output logic on_next
);

   logic [CNT_W-1:0] phase;
   logic [CNT_W-1:0] phase_next;

   always_comb begin
      phase_next = phase;
      if (clear) begin
         phase_next = '0;
      end else if (enable) begin
         if (phase == CNT_W'(PWM_PERIOD - 1)) begin
            phase_next = '0;
         end else begin
            phase_next = phase + CNT_W'(1);
         end
      end
   end

   // Duty is decided on the next phase so the registered coil output lines up with it.
   assign on_next = (phase_next < CNT_W'(HOLD_ON_CYCLES));

   always_ff @(posedge clock or negedge ctrl_reset_n) begin
      if (!ctrl_reset_n) begin
         phase <= '0;
      end else begin
         phase <= phase_next;
      end
   end

endmodule

// File: rtl/magnet_driver.sv
// Unlock-magnet coil controller: pull-in pulse, PWM hold, max-on timeout and forced cooldown.
// Optional MAGNET_SENSE_EN: latch_sensed ends the pull-in phase early.
module magnet_driver
   import magnet_pkg::*;
#(
   parameter int CNT_W           = DEF_CNT_W,
   parameter int PULL_IN_CYCLES  = DEF_PULL_IN_CYCLES,
   parameter int PWM_PERIOD      = DEF_PWM_PERIOD,
   parameter int HOLD_ON_CYCLES  = DEF_HOLD_ON_CYCLES,
   parameter int MAX_ON_CYCLES   = DEF_MAX_ON_CYCLES,
   parameter int COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES
) (
   input  logic       clock,
   input  logic       ctrl_reset_n,
   input  logic       magnet_req,
   input  logic       latch_sensed,
   output logic       coil_drive,
   output logic       busy,
   output logic       timeout,
   output logic [1:0] state_out
);

   state_t           state;
   state_t           state_nx;
   logic [CNT_W-1:0] on_cnt;
   logic [CNT_W-1:0] on_nx;
   logic [CNT_W-1:0] cool_cnt;
   logic [CNT_W-1:0] cool_nx;
   logic             timeout_nx;
   logic             coil_nx;
   logic             pwm_on;
   logic             sense_hit;
   logic             max_hit;
   logic             pull_done;
   logic             cool_done;

`ifdef MAGNET_SENSE_EN
   assign sense_hit = latch_sensed;
`else
   logic sense_unused;
   assign sense_unused = latch_sensed;
   assign sense_hit    = 1'b0;
`endif

   assign max_hit   = (on_cnt == CNT_W'(MAX_ON_CYCLES - 1));
   assign pull_done = (on_cnt == CNT_W'(PULL_IN_CYCLES - 1)) || sense_hit;
   assign cool_done = (cool_cnt == CNT_W'(COOLDOWN_CYCLES - 1));

   // Phase is parked at zero outside HOLD so every hold starts with an on-cycle.
   magnet_pwm #(
      .CNT_W          (CNT_W),
      .PWM_PERIOD     (PWM_PERIOD),
      .HOLD_ON_CYCLES (HOLD_ON_CYCLES)
   ) u_pwm (
      .clock        (clock),
      .ctrl_reset_n (ctrl_reset_n),
      .enable       (state == HOLD),
      .clear        (state != HOLD),
      .on_next      (pwm_on)
   );

   always_comb begin
      state_nx   = state;
      on_nx      = on_cnt;
      cool_nx    = cool_cnt;
      timeout_nx = timeout;
      coil_nx    = 1'b0;
      case (state)
         IDLE: begin
            if (!magnet_req) begin
               timeout_nx = 1'b0;
            end else if (!timeout) begin
               state_nx = PULL_IN;
               on_nx    = '0;
               coil_nx  = 1'b1;
            end
         end
         PULL_IN, HOLD: begin
            on_nx = on_cnt + CNT_W'(1);
            // A dropped request wins, but a coincident max-on still records the fault.
            if (!magnet_req || max_hit) begin
               state_nx = COOLDOWN;
               cool_nx  = '0;
               if (max_hit) begin
                  timeout_nx = 1'b1;
               end
            end else if (state == PULL_IN) begin
               if (pull_done) begin
                  state_nx = HOLD;
                  coil_nx  = pwm_on;
               end else begin
                  coil_nx = 1'b1;
               end
            end else begin
               coil_nx = pwm_on;
            end
         end
         COOLDOWN: begin
            if (cool_done) begin
               state_nx = IDLE;
            end else begin
               cool_nx = cool_cnt + CNT_W'(1);
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge ctrl_reset_n) begin
      if (!ctrl_reset_n) begin
         state      <= IDLE;
         on_cnt     <= '0;
         cool_cnt   <= '0;
         timeout    <= 1'b0;
         coil_drive <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= state_nx;
         on_cnt     <= on_nx;
         cool_cnt   <= cool_nx;
         timeout    <= timeout_nx;
         coil_drive <= coil_nx;
         busy       <= is_busy(state_nx);
      end
   end

   assign state_out = state;

endmodule

// File: tb/tb_magnet_driver.sv
// Self-checking bench for magnet_driver against a time-since-energize reference model.
module tb_magnet_driver;

   localparam int PULL  = 8;
   localparam int PWM   = 4;
   localparam int HON   = 1;
   localparam int MAXON = 64;
   localparam int COOL  = 16;
`ifdef MAGNET_SENSE_EN
   localparam bit SENSE_EN = 1'b1;
`else
   localparam bit SENSE_EN = 1'b0;
`endif

   logic       clock        = 1'b0;
   logic       ctrl_reset_n = 1'b0;
   logic       magnet_req   = 1'b0;
   logic       latch_sensed = 1'b0;
   logic       coil_drive;
   logic       busy;
   logic       timeout;
   logic [1:0] state_out;

   int tests_run    = 0;
   int tests_failed = 0;

   // Model: mode is the expected state, m_ton counts cycles since energize,
   // m_pull is the actual pull-in length of the current energize.
   int m_mode;
   int m_ton;
   int m_tcool;
   int m_pull;
   bit m_tmo;

   always #5 clock = ~clock;

   magnet_driver dut (
      .clock        (clock),
      .ctrl_reset_n (ctrl_reset_n),
      .magnet_req   (magnet_req),
      .latch_sensed (latch_sensed),
      .coil_drive   (coil_drive),
      .busy         (busy),
      .timeout      (timeout),
      .state_out    (state_out)
   );

   function automatic void model_reset();
      m_mode  = 0;
      m_ton   = 0;
      m_tcool = 0;
      m_pull  = PULL;
      m_tmo   = 1'b0;
   endfunction

   function automatic void model_step(bit req, bit sense);
      case (m_mode)
         0: begin
            if (!req) m_tmo = 1'b0;
            else if (!m_tmo) begin
               m_mode = 1;
               m_ton  = 0;
               m_pull = PULL;
            end
         end
         1, 2: begin
            if (!req || m_ton == MAXON - 1) begin
               if (m_ton == MAXON - 1) m_tmo = 1'b1;
               m_mode  = 3;
               m_tcool = 0;
            end else begin
               m_ton++;
               if (m_mode == 1 && (m_ton == m_pull || (SENSE_EN && sense))) begin
                  m_pull = m_ton;
                  m_mode = 2;
               end
            end
         end
         default: begin
            if (m_tcool == COOL - 1) m_mode = 0;
            else m_tcool++;
         end
      endcase
   endfunction

   function automatic logic [4:0] model_vec();
      logic c;
      logic [1:0] st;
      c  = (m_mode == 1) || (m_mode == 2 && ((m_ton - m_pull) % PWM) < HON);
      st = m_mode[1:0];
      return {c, m_mode != 0, m_tmo, st};
   endfunction

   task automatic step_cycle();
      bit r;
      bit s;
      r = magnet_req;
      s = latch_sensed;
      @(posedge clock);
      model_step(r, s);
      #1;
   endtask

   task automatic do_reset();
      magnet_req   = 1'b0;
      latch_sensed = 1'b0;
      ctrl_reset_n = 1'b0;
      @(posedge clock);
      #1;
      ctrl_reset_n = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      logic [4:0] act;
      do_reset();
      act = {coil_drive, busy, timeout, state_out};
      tests_run++;
      if (act !== 5'b0) begin
         tests_failed++;
         $display("[TB] FAIL reset_state: got %b expected %b", act, 5'b0);
      end
      for (int i = 0; i < 3; i++) begin
         step_cycle();
         act = {coil_drive, busy, timeout, state_out};
         tests_run++;
         if (act !== model_vec()) begin
            tests_failed++;
            $display("[TB] FAIL reset_idle cyc %0d: got %b expected %b", i, act, model_vec());
         end
      end
   endtask

   task automatic test_timeout();
      logic [4:0] act;
      int highs;
      do_reset();
      magnet_req = 1'b1;
      highs = 0;
      for (int i = 1; i <= 65; i++) begin
         step_cycle();
         act = {coil_drive, busy, timeout, state_out};
         if (coil_drive === 1'b1) highs++;
         tests_run++;
         if (act !== model_vec()) begin
            tests_failed++;
            $display("[TB] FAIL hold_wave cyc %0d: got coil/busy/tmo/st=%b expected %b", i, act, model_vec());
         end
      end
      tests_run++;
      if (highs != PULL + (MAXON - PULL) / PWM * HON) begin
         tests_failed++;
         $display("[TB] FAIL coil_high_total: got %0d expected %0d", highs, PULL + (MAXON - PULL) / PWM * HON);
      end
      tests_run++;
      if ({coil_drive, busy, timeout, state_out} !== 5'b01111) begin
         tests_failed++;
         $display("[TB] FAIL timeout_entry: got %b expected 01111", {coil_drive, busy, timeout, state_out});
      end
      for (int i = 0; i < COOL + 5; i++) begin
         step_cycle();
         act = {coil_drive, busy, timeout, state_out};
         tests_run++;
         if (act !== model_vec()) begin
            tests_failed++;
            $display("[TB] FAIL cooldown_stuck cyc %0d: got %b expected %b", i, act, model_vec());
         end
      end
      tests_run++;
      if ({coil_drive, busy, timeout, state_out} !== 5'b00100) begin
         tests_failed++;
         $display("[TB] FAIL idle_locked: got %b expected 00100", {coil_drive, busy, timeout, state_out});
      end
      magnet_req = 1'b0;
      step_cycle();
      tests_run++;
      if ({coil_drive, busy, timeout, state_out} !== 5'b00000) begin
         tests_failed++;
         $display("[TB] FAIL rearm: got %b expected 00000", {coil_drive, busy, timeout, state_out});
      end
      magnet_req = 1'b1;
      step_cycle();
      tests_run++;
      if ({coil_drive, busy, timeout, state_out} !== 5'b11001) begin
         tests_failed++;
         $display("[TB] FAIL restart: got %b expected 11001", {coil_drive, busy, timeout, state_out});
      end
   endtask

   task automatic test_early_drop();
      logic [4:0] act;
      int cool_seen;
      do_reset();
      magnet_req = 1'b1;
      for (int i = 0; i < 3; i++) step_cycle();
      magnet_req = 1'b0;
      step_cycle();
      tests_run++;
      if ({coil_drive, busy, timeout, state_out} !== 5'b01011) begin
         tests_failed++;
         $display("[TB] FAIL drop_to_cool: got %b expected 01011", {coil_drive, busy, timeout, state_out});
      end
      magnet_req = 1'b1;
      cool_seen = 1;
      for (int i = 5; i <= 21; i++) begin
         step_cycle();
         act = {coil_drive, busy, timeout, state_out};
         if (state_out === 2'd3) cool_seen++;
         tests_run++;
         if (act !== model_vec()) begin
            tests_failed++;
            $display("[TB] FAIL drop_seq cyc %0d: got %b expected %b", i, act, model_vec());
         end
         if (i == 20) begin
            tests_run++;
            if (act !== 5'b00000) begin
               tests_failed++;
               $display("[TB] FAIL cool_exit: got %b expected 00000", act);
            end
         end
      end
      tests_run++;
      if (cool_seen != COOL) begin
         tests_failed++;
         $display("[TB] FAIL cool_len: got %0d expected %0d", cool_seen, COOL);
      end
      tests_run++;
      if ({coil_drive, busy, timeout, state_out} !== 5'b11001) begin
         tests_failed++;
         $display("[TB] FAIL repull: got %b expected 11001", {coil_drive, busy, timeout, state_out});
      end
   endtask

   task automatic test_async_reset();
      logic [4:0] act;
      do_reset();
      magnet_req = 1'b1;
      for (int i = 0; i < 13; i++) step_cycle();
      act = {coil_drive, busy, timeout, state_out};
      tests_run++;
      if (act !== model_vec()) begin
         tests_failed++;
         $display("[TB] FAIL pre_reset_hold: got %b expected %b", act, model_vec());
      end
      #3;
      ctrl_reset_n = 1'b0;
      #1;
      act = {coil_drive, busy, timeout, state_out};
      tests_run++;
      if (act !== 5'b00000) begin
         tests_failed++;
         $display("[TB] FAIL async_reset: got %b expected 00000", act);
      end
      #2;
      ctrl_reset_n = 1'b1;
      model_reset();
      step_cycle();
      act = {coil_drive, busy, timeout, state_out};
      tests_run++;
      if (act !== model_vec()) begin
         tests_failed++;
         $display("[TB] FAIL post_reset: got %b expected %b", act, model_vec());
      end
   endtask

   task automatic test_sense();
      logic [4:0] act;
      logic [1:0] exp_st;
      int on_cycles;
      do_reset();
      magnet_req = 1'b1;
      for (int i = 0; i < 3; i++) step_cycle();
      latch_sensed = 1'b1;
      step_cycle();
      latch_sensed = 1'b0;
      exp_st = SENSE_EN ? 2'd2 : 2'd1;
      tests_run++;
      if (state_out !== exp_st) begin
         tests_failed++;
         $display("[TB] FAIL sense_hold_entry: got %0d expected %0d", state_out, exp_st);
      end
      on_cycles = 4;
      for (int i = 5; i <= 70; i++) begin
         step_cycle();
         act = {coil_drive, busy, timeout, state_out};
         if (state_out === 2'd1 || state_out === 2'd2) on_cycles++;
         tests_run++;
         if (act !== model_vec()) begin
            tests_failed++;
            $display("[TB] FAIL sense_seq cyc %0d: got %b expected %b", i, act, model_vec());
         end
      end
      tests_run++;
      if (on_cycles != MAXON) begin
         tests_failed++;
         $display("[TB] FAIL sense_on_time: got %0d expected %0d", on_cycles, MAXON);
      end
   endtask

   task automatic test_random();
      logic [4:0] act;
      do_reset();
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 19) == 0) magnet_req = ~magnet_req;
         latch_sensed = ($urandom_range(0, 7) == 0);
         step_cycle();
         act = {coil_drive, busy, timeout, state_out};
         tests_run++;
         if (act !== model_vec()) begin
            tests_failed++;
            $display("[TB] FAIL random cyc %0d: got %b expected %b", i, act, model_vec());
         end
      end
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      model_reset();
      test_reset();
      test_timeout();
      test_early_drop();
      test_async_reset();
      test_sense();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
